mem_stage: RTL and testbench

Memory stage of the 5-stage pipeline. Sits between the X/M latch and the writeback stage, and owns the M/W pipeline registers.
- Issues lw/sw accesses to a data memory that has variable latency, using a req/ready handshake.
- Stalls upstream while an access is outstanding.
- Presents registered results, destination register and instruction flags to writeback.
- Inserts bubbles (all flags zero) whenever no instruction completes.

---
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline memory stage. Issues lw/sw accesses to a
//                variable-latency data memory with a req/ready handshake,
//                holds the X/M latch while an access is outstanding, and
//                owns the M/W pipeline registers feeding writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_xm,
    input  logic [17:0]       flags_xm,
    input  logic [31:0]       exec_out_xm,
    input  logic [31:0]       store_data_xm,
    input  logic [4:0]        rd_xm,
    input  logic [26:0]       target_xm,
    input  logic              exception_xm,
    input  logic              flush,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              dmem_wren,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic              stall_xm,
    output logic              valid_mw,
    output logic [17:0]       flags_mw,
    output logic [31:0]       exec_out_mw,
    output logic [31:0]       mem_out_mw,
    output logic [4:0]        rd_mw,
    output logic [26:0]       target_mw,
    output logic              exception_mw,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0]  c_ST_IDLE         = 2'd0;
    localparam logic [1:0]  c_ST_WAIT         = 2'd1;
    localparam logic [1:0]  c_ST_WAIT_FLUSHED = 2'd2;
    localparam logic [17:0] c_SW_BIT          = 18'h00200;
    localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_valid_mw;
    logic [17:0]      r_flags_mw;
    logic [31:0]      r_exec_out_mw;
    logic [31:0]      r_mem_out_mw;
    logic [4:0]       r_rd_mw;
    logic [26:0]      r_target_mw;
    logic             r_exception_mw;
    logic [CNT_W-1:0] r_stall_count;

    logic w_memop;
    logic w_legal;
    logic w_idle;
    logic w_req;
    logic w_stall;
    logic w_capture;
    logic w_valid_next;
    logic w_illegal;
    logic w_load_done;

    // Decode the X/M instruction and derive handshake / capture conditions
    always_comb begin
        w_memop      = valid_xm & (flags_xm[9] | flags_xm[10]);
        w_legal      = ((exec_out_xm >> ADDR_W) == 32'd0);
        w_idle       = (r_state == c_ST_IDLE);
        // Once a request leaves IDLE it is held until the memory accepts it
        w_req        = (w_idle & w_memop & w_legal) | !w_idle;
        w_stall      = w_req & !dmem_ready;
        // A real instruction reaches M/W only from IDLE without stalling, or
        // on the completing cycle of a non-flushed wait
        w_capture    = (w_idle & !w_stall) | ((r_state == c_ST_WAIT) & dmem_ready);
        w_valid_next = w_capture & valid_xm & !flush;
        w_illegal    = w_memop & !w_legal;
        w_load_done  = w_req & dmem_ready & flags_xm[10];
    end

    // Next-state selection for the access FSM
    always_comb begin
        w_state_next = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE: begin
                if (w_stall)
                    w_state_next = flush ? c_ST_WAIT_FLUSHED : c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (!dmem_ready)
                    w_state_next = flush ? c_ST_WAIT_FLUSHED : c_ST_WAIT;
            end
            c_ST_WAIT_FLUSHED: begin
                if (!dmem_ready)
                    w_state_next = c_ST_WAIT_FLUSHED;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM state, M/W pipeline registers and saturating stall counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_valid_mw     <= 1'b0;
            r_flags_mw     <= 18'd0;
            r_exec_out_mw  <= 32'd0;
            r_mem_out_mw   <= 32'd0;
            r_rd_mw        <= 5'd0;
            r_target_mw    <= 27'd0;
            r_exception_mw <= 1'b0;
            r_stall_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_valid_mw     <= w_valid_next;
                // Illegal stores lose their sw flag so writeback never commits them
                r_flags_mw     <= w_valid_next ?
                                  (flags_xm & ~(w_illegal ? c_SW_BIT : 18'd0)) : 18'd0;
                r_exec_out_mw  <= exec_out_xm;
                r_mem_out_mw   <= (w_valid_next & w_load_done) ? dmem_rdata : 32'd0;
                r_rd_mw        <= rd_xm;
                r_target_mw    <= target_xm;
                r_exception_mw <= w_valid_next & (exception_xm | w_illegal);
            end else begin
                r_valid_mw     <= 1'b0;
                r_flags_mw     <= 18'd0;
                r_exec_out_mw  <= 32'd0;
                r_mem_out_mw   <= 32'd0;
                r_rd_mw        <= 5'd0;
                r_target_mw    <= 27'd0;
                r_exception_mw <= 1'b0;
            end
            if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + c_CNT_ONE;
        end
    end

    assign dmem_req     = w_req;
    assign dmem_wren    = w_req & flags_xm[9];
    assign dmem_addr    = exec_out_xm[ADDR_W-1:0];
    assign dmem_wdata   = store_data_xm;
    assign stall_xm     = w_stall;
    assign valid_mw     = r_valid_mw;
    assign flags_mw     = r_flags_mw;
    assign exec_out_mw  = r_exec_out_mw;
    assign mem_out_mw   = r_mem_out_mw;
    assign rd_mw        = r_rd_mw;
    assign target_mw    = r_target_mw;
    assign exception_mw = r_exception_mw;
    assign stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage with an expected-M/W
//                scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;

    localparam logic [17:0] c_ADD = 18'h00001;
    localparam logic [17:0] c_SW  = 18'h00200;
    localparam logic [17:0] c_LW  = 18'h00400;

    typedef struct packed {
        logic        valid;
        logic [17:0] flags;
        logic [31:0] exec;
        logic [31:0] mem;
        logic [4:0]  rd;
        logic [26:0] target;
        logic        exc;
    } mw_t;

    logic              clock;
    logic              reset;
    logic              valid_xm;
    logic [17:0]       flags_xm;
    logic [31:0]       exec_out_xm;
    logic [31:0]       store_data_xm;
    logic [4:0]        rd_xm;
    logic [26:0]       target_xm;
    logic              exception_xm;
    logic              flush;
    logic [31:0]       dmem_rdata;
    logic              dmem_ready;
    logic              dmem_req;
    logic              dmem_wren;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              stall_xm;
    logic              valid_mw;
    logic [17:0]       flags_mw;
    logic [31:0]       exec_out_mw;
    logic [31:0]       mem_out_mw;
    logic [4:0]        rd_mw;
    logic [26:0]       target_mw;
    logic              exception_mw;
    logic [CNT_W-1:0]  stall_count;

    int  n_checks = 0;
    int  n_errors = 0;
    mw_t sb_q[$];
    mw_t c_BUBBLE = '0;

    mem_stage #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .valid_xm(valid_xm), .flags_xm(flags_xm), .exec_out_xm(exec_out_xm),
        .store_data_xm(store_data_xm), .rd_xm(rd_xm), .target_xm(target_xm),
        .exception_xm(exception_xm), .flush(flush),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .dmem_wren(dmem_wren), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .stall_xm(stall_xm),
        .valid_mw(valid_mw), .flags_mw(flags_mw), .exec_out_mw(exec_out_mw),
        .mem_out_mw(mem_out_mw), .rd_mw(rd_mw), .target_mw(target_mw),
        .exception_mw(exception_mw), .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic mw_t mk(input logic v, input logic [17:0] f, input logic [31:0] e,
                               input logic [31:0] m, input logic [4:0] r,
                               input logic [26:0] t, input logic x);
        mw_t o;
        o.valid = v; o.flags = f; o.exec = e; o.mem = m; o.rd = r; o.target = t; o.exc = x;
        return o;
    endfunction

    task automatic set_xm(input logic v, input logic [17:0] f, input logic [31:0] e,
                          input logic [31:0] sd, input logic [4:0] r, input logic [26:0] t);
        valid_xm = v; flags_xm = f; exec_out_xm = e; store_data_xm = sd;
        rd_xm = r; target_xm = t; exception_xm = 1'b0;
    endtask

    // One pipeline cycle: push expectation, check handshake, clock, pop and compare M/W
    task automatic cycle(input string tag, input logic exp_req, input logic exp_stall,
                         input mw_t exp);
        mw_t e;
        sb_q.push_back(exp);
        #1;
        chk({tag, ".dmem_req"}, {31'd0, dmem_req}, {31'd0, exp_req});
        chk({tag, ".stall_xm"}, {31'd0, stall_xm}, {31'd0, exp_stall});
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".valid_mw"},     {31'd0, valid_mw},     {31'd0, e.valid});
        chk({tag, ".flags_mw"},     {14'd0, flags_mw},     {14'd0, e.flags});
        chk({tag, ".exec_out_mw"},  exec_out_mw,           e.exec);
        chk({tag, ".mem_out_mw"},   mem_out_mw,            e.mem);
        chk({tag, ".rd_mw"},        {27'd0, rd_mw},        {27'd0, e.rd});
        chk({tag, ".target_mw"},    {5'd0, target_mw},     {5'd0, e.target});
        chk({tag, ".exception_mw"}, {31'd0, exception_mw}, {31'd0, e.exc});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; dmem_rdata = 32'd0; dmem_ready = 1'b0;
        set_xm(1'b0, 18'd0, 32'd0, 32'd0, 5'd0, 27'd0);
        #12;
        chk("reset.valid_mw", {31'd0, valid_mw}, 32'd0);
        chk("reset.flags_mw", {14'd0, flags_mw}, 32'd0);
        chk("reset.dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("reset.stall_count", {16'd0, stall_count}, 32'd0);
        #1 reset = 1'b0;

        // ALU op passes straight through in one cycle
        set_xm(1'b1, c_ADD, 32'h0000_0011, 32'd0, 5'd5, 27'h0000123);
        cycle("add", 1'b0, 1'b0, mk(1'b1, c_ADD, 32'h11, 32'd0, 5'd5, 27'h0000123, 1'b0));

        // lw with three wait cycles
        set_xm(1'b1, c_LW, 32'h0000_0004, 32'd0, 5'd7, 27'd0);
        dmem_ready = 1'b0;
        #1 chk("lw.dmem_addr", {20'd0, dmem_addr}, 32'h4);
        chk("lw.dmem_wren", {31'd0, dmem_wren}, 32'd0);
        for (int i = 0; i < 3; i++) cycle("lw_wait", 1'b1, 1'b1, c_BUBBLE);
        dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        cycle("lw_done", 1'b1, 1'b0, mk(1'b1, c_LW, 32'h4, 32'hDEAD_BEEF, 5'd7, 27'd0, 1'b0));
        chk("lw.stall_count", {16'd0, stall_count}, 32'd3);

        // sw with zero wait states
        set_xm(1'b1, c_SW, 32'h0000_0010, 32'h0000_1234, 5'd0, 27'd0);
        dmem_ready = 1'b1;
        #1 chk("sw.dmem_wren", {31'd0, dmem_wren}, 32'd1);
        chk("sw.dmem_wdata", dmem_wdata, 32'h1234);
        chk("sw.dmem_addr", {20'd0, dmem_addr}, 32'h10);
        cycle("sw", 1'b1, 1'b0, mk(1'b1, c_SW, 32'h10, 32'd0, 5'd0, 27'd0, 1'b0));

        // lw with zero wait states returns data directly
        set_xm(1'b1, c_LW, 32'h0000_0FFC, 32'd0, 5'd9, 27'd0);
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_0001;
        cycle("lw0", 1'b1, 1'b0, mk(1'b1, c_LW, 32'hFFC, 32'hCAFE_0001, 5'd9, 27'd0, 1'b0));

        // Out-of-range addresses raise an exception without a request
        dmem_ready = 1'b0;
        set_xm(1'b1, c_LW, 32'h0000_1000, 32'd0, 5'd3, 27'd0);
        cycle("ill_lw", 1'b0, 1'b0, mk(1'b1, c_LW, 32'h1000, 32'd0, 5'd3, 27'd0, 1'b1));
        set_xm(1'b1, c_SW, 32'h8000_0000, 32'h55, 5'd0, 27'd0);
        cycle("ill_sw", 1'b0, 1'b0, mk(1'b1, 18'd0, 32'h8000_0000, 32'd0, 5'd0, 27'd0, 1'b1));

        // Flush of a non-memop in IDLE produces an invalid, flag-free entry
        set_xm(1'b1, c_ADD, 32'h22, 32'd0, 5'd4, 27'h5);
        flush = 1'b1;
        cycle("flush_add", 1'b0, 1'b0, mk(1'b0, 18'd0, 32'h22, 32'd0, 5'd4, 27'h5, 1'b0));
        flush = 1'b0;

        // sw flushed in its first wait cycle: request held, bubbles only
        set_xm(1'b1, c_SW, 32'h0000_0020, 32'h0000_ABCD, 5'd0, 27'd0);
        dmem_ready = 1'b0;
        cycle("swf_w0", 1'b1, 1'b1, c_BUBBLE);
        flush = 1'b1;
        cycle("swf_w1", 1'b1, 1'b1, c_BUBBLE);
        flush = 1'b0; dmem_ready = 1'b1;
        cycle("swf_done", 1'b1, 1'b0, c_BUBBLE);
        dmem_ready = 1'b0;
        set_xm(1'b1, c_ADD, 32'h33, 32'd0, 5'd6, 27'd0);
        cycle("post_flush", 1'b0, 1'b0, mk(1'b1, c_ADD, 32'h33, 32'd0, 5'd6, 27'd0, 1'b0));
        chk("swf.stall_count", {16'd0, stall_count}, 32'd5);

        // Asynchronous reset while a lw is outstanding
        set_xm(1'b1, c_LW, 32'h8, 32'd0, 5'd2, 27'd0);
        cycle("rst_lw", 1'b1, 1'b1, c_BUBBLE);
        #2 reset = 1'b1; valid_xm = 1'b0;
        #1;
        chk("rst_mid.dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_mid.stall_xm", {31'd0, stall_xm}, 32'd0);
        chk("rst_mid.stall_count", {16'd0, stall_count}, 32'd0);
        chk("rst_mid.valid_mw", {31'd0, valid_mw}, 32'd0);
        chk("rst_mid.exec_out_mw", exec_out_mw, 32'd0);
        #1 reset = 1'b0;
        set_xm(1'b1, c_ADD, 32'h44, 32'd0, 5'd1, 27'd0);
        cycle("after_rst", 1'b0, 1'b0, mk(1'b1, c_ADD, 32'h44, 32'd0, 5'd1, 27'd0, 1'b0));

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
